pulse_meas_sched: RTL and testbench
===================================

Name: pulse_meas_sched

Overview:
- Round-robin measurement scheduler that shares one pulse-width counter across NUM_CH pulse inputs.
- For each enabled channel in turn, it waits for a clean low→high→low pulse, counts its high time in clock cycles, and reports {channel, width, status} over a valid/ready interface.
- Sits between raw pulse sources and the downstream result consumer (CSR or logging FIFO).

Parameters:
- NUM_CH, 4, number of pulse input channels (2..16).
- CH_W, 2, channel index width; must equal clog2(NUM_CH).
- CNT_W, 16, width counter width.
- TIMEOUT, 1000, max cycles spent in WAIT_LOW or WAIT_RISE before giving up (≥2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  scheduler run enable.
- ch_mask  in  NUM_CH  per-channel enable; sampled only in SELECT.
- pulse_in  in  NUM_CH  pulse inputs, already synchronous to clk.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_ch  out  CH_W  channel index of the result.
- res_width  out  CNT_W  measured high time in cycles.
- res_status  out  2  00 ok, 01 no pulse (timeout), 10 stuck high, 11 counter overflow.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - FSM→IDLE; res_valid=0, res_ch=0, res_width=0, res_status=00, busy=0.
  - Round-robin pointer last_ch=NUM_CH-1, so channel 0 is served first.
  - Sample register cleared; counter and timer cleared.
  - Reset mid-operation discards any measurement or pending result.
- Input sampling:
  - Every cycle, s <= pulse_in[cur_ch]; rising edge = s high while prev sample low.
  - A pulse high on pulse_in for exactly W cycles yields res_width=W.
- FSM states:
  - IDLE: if enable and |ch_mask → SELECT.
  - SELECT (1 cycle):
    - cur_ch = first masked channel after last_ch, searching upward with wrap-around.
    - If only one channel is masked, it is reselected.
    - Clear timer and counter → WAIT_LOW.
    - If ch_mask is now all-zero → IDLE.
  - WAIT_LOW:
    - s low → WAIT_RISE, timer cleared. This guarantees a pulse already in progress is never measured.
    - Timer reaching TIMEOUT-1 → REPORT with status 10, width 0.
  - WAIT_RISE:
    - s high → COUNT, counter=1.
    - Timer reaching TIMEOUT-1 → REPORT with status 01, width 0.
  - COUNT:
    - s high → counter+1.
    - s low → REPORT with status 00, width=counter.
    - Counter reaching all-ones while s is still high → REPORT with status 11, width=all-ones; no wrap.
  - REPORT:
    - res_valid=1; res_ch, res_width and res_status are registered and held stable until res_valid && res_ready.
    - On handshake: last_ch=cur_ch; next state = SELECT if enable else IDLE.
    - res_valid drops the cycle after the handshake.
- Latency: res_valid is asserted 2 cycles after pulse_in falls (1 sample register + 1 FSM transition).
- enable=0:
  - In SELECT, WAIT_LOW, WAIT_RISE or COUNT: abort to IDLE at the next edge; no result; last_ch unchanged.
  - In REPORT: ignored; the result is held until accepted.
- Masks and other channels:
  - Changing ch_mask mid-measurement has no effect until the next SELECT.
  - Activity on unselected channels is ignored; pulses on them are not queued.
- Backpressure: while REPORT waits for res_ready, no measurement runs and pulse_in is ignored.
- Simultaneous events:
  - Timeout and edge in the same cycle: the edge wins (WAIT_LOW→WAIT_RISE, WAIT_RISE→COUNT).
  - Overflow and falling edge in the same cycle: reported as status 00 with width all-ones.
- busy = (state != IDLE).

Test Plan:
- Single channel: mask=0001, ch0 low 3 cycles, high 5 cycles, low; res_ready=1 → one result {ch=0, width=5, status=00}; res_valid seen 2 cycles after the fall.
- Round-robin order: mask=1011, periodic 4-cycle pulses on all channels → results in order ch 0,1,3,0,1 with width 4; ch2 never reported.
- No pulse: TIMEOUT=20, mask=0010, ch1 held low → {ch=1, width=0, status=01} after 20 cycles in WAIT_RISE; then ch1 is reselected.
- Stuck high and overflow:
  - Stuck high: ch0 held high from reset → status 10.
  - Overflow: CNT_W=4, a 20-cycle pulse → {width=15, status=11}.
- Backpressure and enable:
  - res_ready low 10 cycles → res_* stable and no new measurement starts.
  - enable dropped mid-COUNT → busy=0 next cycle, no result.
- Reset mid-COUNT: rst_n low 1 cycle → all outputs zero; after reset the first result is from ch0.

Source files
------------

// File: rtl/pulse_meas_sched.sv
// Round-robin pulse-width meter: one counter shared by NUM_CH inputs; result valid 2 cycles after the fall.
// Result is held in REPORT until res_ready; no measurement runs while it waits.
module pulse_meas_sched #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] pulse_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CH_W-1:0]   res_ch,
    output logic [CNT_W-1:0]  res_width,
    output logic [1:0]        res_status,
    output logic              busy
);

    localparam int               TM_W     = $clog2(TIMEOUT);
    localparam logic [TM_W-1:0]  TM_LAST  = TM_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [1:0]       ST_OK    = 2'b00;
    localparam logic [1:0]       ST_NOPUL = 2'b01;
    localparam logic [1:0]       ST_STUCK = 2'b10;
    localparam logic [1:0]       ST_OVF   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        WAIT_LOW,
        WAIT_RISE,
        COUNT,
        REPORT
    } state_t;

    state_t            state, state_nx;
    logic [CH_W-1:0]   last_ch, cur_ch, sel_ch, scan_ch, samp_ch;
    logic              sel_found;
    logic              s;
    logic [TM_W-1:0]   timer;
    logic [CNT_W-1:0]  cnt;
    logic              rep_load;
    logic [CNT_W-1:0]  rep_width;
    logic [1:0]        rep_status;

    // First masked channel strictly after last_ch, wrapping; last_ch itself is checked last.
    always_comb begin
        sel_ch    = last_ch;
        sel_found = 1'b0;
        scan_ch   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            scan_ch = CH_W'((int'(last_ch) + i) % NUM_CH);
            if (!sel_found && ch_mask[scan_ch]) begin
                sel_found = 1'b1;
                sel_ch    = scan_ch;
            end
        end
    end

    // While selecting, sample the channel being chosen so WAIT_LOW never sees a stale channel.
    assign samp_ch = (state == SELECT) ? sel_ch : cur_ch;

    always_comb begin
        state_nx   = state;
        rep_load   = 1'b0;
        rep_width  = '0;
        rep_status = ST_OK;
        case (state)
            IDLE: begin
                if (enable && (|ch_mask)) state_nx = SELECT;
            end
            SELECT: begin
                if (!enable || !sel_found) state_nx = IDLE;
                else                       state_nx = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else if (!s) begin
                    state_nx = WAIT_RISE;
                end else if (timer == TM_LAST) begin
                    state_nx   = REPORT;
                    rep_load   = 1'b1;
                    rep_status = ST_STUCK;
                end
            end
            WAIT_RISE: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else if (s) begin
                    state_nx = COUNT;
                end else if (timer == TM_LAST) begin
                    state_nx   = REPORT;
                    rep_load   = 1'b1;
                    rep_status = ST_NOPUL;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else if (!s) begin
                    state_nx  = REPORT;
                    rep_load  = 1'b1;
                    rep_width = cnt;
                end else if (cnt == CNT_MAX) begin
                    state_nx   = REPORT;
                    rep_load   = 1'b1;
                    rep_width  = CNT_MAX;
                    rep_status = ST_OVF;
                end
            end
            REPORT: begin
                if (res_ready) state_nx = enable ? SELECT : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_ch    <= CH_W'(NUM_CH - 1);
            cur_ch     <= '0;
            s          <= 1'b0;
            timer      <= '0;
            cnt        <= '0;
            res_ch     <= '0;
            res_width  <= '0;
            res_status <= ST_OK;
        end else begin
            state <= state_nx;
            s     <= pulse_in[samp_ch];
            case (state)
                SELECT: begin
                    cur_ch <= sel_ch;
                    timer  <= '0;
                    cnt    <= '0;
                end
                WAIT_LOW:  timer <= s ? timer + 1'b1 : '0;
                WAIT_RISE: begin
                    timer <= timer + 1'b1;
                    if (s) cnt <= CNT_W'(1);
                end
                COUNT: begin
                    if (s && (cnt != CNT_MAX)) cnt <= cnt + 1'b1;
                end
                REPORT: begin
                    if (res_ready) last_ch <= cur_ch;
                end
                default: ;
            endcase
            if (rep_load) begin
                res_ch     <= cur_ch;
                res_width  <= rep_width;
                res_status <= rep_status;
            end
        end
    end

    assign res_valid = (state == REPORT);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pulse_meas_sched.sv
// Bench for pulse_meas_sched (4 channels, 4-bit counter, 20-cycle timeout): vector table plus corner-case sequences.
module tb_pulse_meas_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] ch_mask;
    logic [3:0] pulse_in;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] res_ch;
    logic [3:0] res_width;
    logic [1:0] res_status;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] ch;
        logic [3:0] w;
        logic [1:0] st;
    } res_t;

    typedef struct {
        logic [3:0] mask;
        int         ch;
        int         low;
        int         high;
        logic [1:0] e_ch;
        logic [3:0] e_w;
        logic [1:0] e_st;
    } vec_t;

    res_t exp_q[$];
    res_t mon_exp;
    res_t mon_got;
    vec_t vecs[7];

    pulse_meas_sched #(
        .NUM_CH (4),
        .CH_W   (2),
        .CNT_W  (4),
        .TIMEOUT(20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .ch_mask   (ch_mask),
        .pulse_in  (pulse_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ch    (res_ch),
        .res_width (res_width),
        .res_status(res_status),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic res_t mk_res(input logic [1:0] c, input logic [3:0] w, input logic [1:0] st);
        mk_res = {c, w, st};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_empty(input int bound, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            step(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending %0d expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        ch_mask  = v.mask;
        pulse_in = '0;
        enable   = 1'b1;
        exp_q.push_back(mk_res(v.e_ch, v.e_w, v.e_st));
        step(v.low);
        if (v.high > 0) pulse_in = 4'b0001 << v.ch;
        step(v.high);
        pulse_in = '0;
        wait_empty(100, "vec");
        enable = 1'b0;
        step(3);
    endtask

    // Scoreboard: every accepted result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            checks++;
            mon_got = {res_ch, res_width, res_status};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got ch=%0d w=%0d st=%0d expected none",
                         res_ch, res_width, res_status);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL result got ch=%0d w=%0d st=%0d expected ch=%0d w=%0d st=%0d",
                             res_ch, res_width, res_status, mon_exp.ch, mon_exp.w, mon_exp.st);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  c;
        logic seen;

        vecs[0] = '{4'b0001, 0, 3, 5,  2'd0, 4'd5,  2'b00};
        vecs[1] = '{4'b0010, 1, 3, 1,  2'd1, 4'd1,  2'b00};
        vecs[2] = '{4'b0100, 2, 4, 15, 2'd2, 4'd15, 2'b00};
        vecs[3] = '{4'b1000, 3, 2, 16, 2'd3, 4'd15, 2'b11};
        vecs[4] = '{4'b0001, 0, 3, 20, 2'd0, 4'd15, 2'b11};
        vecs[5] = '{4'b0010, 1, 3, 0,  2'd1, 4'd0,  2'b01};
        vecs[6] = '{4'b0001, 0, 0, 30, 2'd0, 4'd0,  2'b10};

        rst_n     = 1'b0;
        enable    = 1'b0;
        ch_mask   = '0;
        pulse_in  = '0;
        res_ready = 1'b1;
        step(3);
        chk("rst_valid",  res_valid,  0);
        chk("rst_busy",   busy,       0);
        chk("rst_ch",     res_ch,     0);
        chk("rst_width",  res_width,  0);
        chk("rst_status", res_status, 0);
        rst_n = 1'b1;
        step(2);

        // Round robin over mask 1011 with identical periodic pulses on every channel
        ch_mask = 4'b1011;
        enable  = 1'b1;
        exp_q.push_back(mk_res(2'd0, 4'd4, 2'b00));
        exp_q.push_back(mk_res(2'd1, 4'd4, 2'b00));
        exp_q.push_back(mk_res(2'd3, 4'd4, 2'b00));
        exp_q.push_back(mk_res(2'd0, 4'd4, 2'b00));
        exp_q.push_back(mk_res(2'd1, 4'd4, 2'b00));
        c = 0;
        while (exp_q.size() != 0 && c < 400) begin
            step(1);
            pulse_in = ((c % 8) < 4) ? 4'hF : 4'h0;
            c++;
        end
        enable   = 1'b0;
        pulse_in = '0;
        wait_empty(1, "rr");
        step(3);

        // Single channel: valid appears exactly 2 cycles after the fall
        ch_mask = 4'b0001;
        enable  = 1'b1;
        exp_q.push_back(mk_res(2'd0, 4'd5, 2'b00));
        step(3);
        pulse_in = 4'b0001;
        step(5);
        pulse_in = '0;
        @(posedge clk);
        @(negedge clk);
        chk("lat_fall_plus1", res_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_fall_plus2", res_valid, 1);
        step(1);
        wait_empty(20, "lat");
        enable = 1'b0;
        step(3);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // No pulse: timeout after 20 cycles in WAIT_RISE, then the same channel is reselected
        ch_mask = 4'b0010;
        enable  = 1'b1;
        exp_q.push_back(mk_res(2'd1, 4'd0, 2'b01));
        exp_q.push_back(mk_res(2'd1, 4'd3, 2'b00));
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (res_valid) break;
        end
        chk("nopulse_latency", n, 23);
        step(1);
        step(3);
        pulse_in = 4'b0010;
        step(3);
        pulse_in = '0;
        wait_empty(60, "nopulse");
        enable = 1'b0;
        step(3);

        // Backpressure: result held stable, activity on the input ignored
        res_ready = 1'b0;
        ch_mask   = 4'b0001;
        enable    = 1'b1;
        exp_q.push_back(mk_res(2'd0, 4'd6, 2'b00));
        step(3);
        pulse_in = 4'b0001;
        step(6);
        pulse_in = '0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = res_valid;
            step(1);
        end
        chk("bp_valid_seen", seen, 1);
        for (int i = 0; i < 10; i++) begin
            pulse_in = (i >= 2 && i < 5) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            chk("bp_hold", {res_valid, busy, res_ch, res_width, res_status},
                {1'b1, 1'b1, 2'd0, 4'd6, 2'b00});
            step(1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        step(1);
        wait_empty(1, "bp");
        step(3);

        // enable dropped mid-COUNT aborts with no result
        ch_mask = 4'b0001;
        enable  = 1'b1;
        step(3);
        pulse_in = 4'b0001;
        step(3);
        @(negedge clk);
        chk("abort_busy_before", busy, 1);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy_after", busy, 0);
        step(3);
        pulse_in = '0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        chk("abort_no_result", seen, 0);
        step(1);

        // Reset mid-COUNT clears outputs and restores channel 0 priority
        ch_mask = 4'b0010;
        enable  = 1'b1;
        exp_q.push_back(mk_res(2'd1, 4'd2, 2'b00));
        step(3);
        pulse_in = 4'b0010;
        step(2);
        pulse_in = '0;
        wait_empty(40, "pre_rst");
        step(3);
        pulse_in = 4'b0010;
        step(3);
        rst_n    = 1'b0;
        enable   = 1'b0;
        pulse_in = '0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_outputs", {res_valid, busy, res_ch, res_width, res_status}, 0);
        rst_n = 1'b1;
        step(2);
        ch_mask = 4'b1111;
        enable  = 1'b1;
        exp_q.push_back(mk_res(2'd0, 4'd3, 2'b00));
        step(3);
        pulse_in = 4'hF;
        step(3);
        pulse_in = '0;
        wait_empty(40, "post_rst");
        enable = 1'b0;
        step(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
